// File: rtl/axi_lite_register_responder.sv
// AXI4-Lite slave exposing a bank of 32-bit registers with a configurable response delay.
// Independent read and write engines, one outstanding transaction per direction.
`timescale 1ns/1ps

module axi_lite_register_responder #(
   parameter int AddressWidth    = 20,
   parameter int RegisterCount   = 16,
   parameter int BaseAddress     = 0,
   parameter int ResponseLatency = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [AddressWidth-1:0] awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [31:0]             wdata,
   input  logic [3:0]              wstrb,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [AddressWidth-1:0] araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [31:0]             rdata,
   output logic [1:0]              rresp
);

   localparam int IndexWidth = (RegisterCount > 1) ? $clog2(RegisterCount) : 1;
   localparam logic [AddressWidth-1:0] BaseAddr = AddressWidth'(BaseAddress);
   localparam logic [AddressWidth-1:0] RegLimit = AddressWidth'(RegisterCount);
   localparam logic [7:0] WaitLast = 8'(ResponseLatency - 1);
   localparam logic [7:0] ReadWait = 8'(ResponseLatency);

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} write_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} read_state_t;

   function automatic logic is_legal(input logic [AddressWidth-1:0] addr);
      logic [AddressWidth-1:0] offset;
      offset = addr - BaseAddr;
      return (addr >= BaseAddr) && (addr[1:0] == 2'b00) && ((offset >> 2) < RegLimit);
   endfunction

   function automatic logic [IndexWidth-1:0] to_index(input logic [AddressWidth-1:0] addr);
      return IndexWidth'((addr - BaseAddr) >> 2);
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_value,
                                               input logic [31:0] new_value,
                                               input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_value;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_value[8*b +: 8];
      end
      return merged;
   endfunction

   logic [31:0]             regs [RegisterCount];
   logic                    ready_en;

   write_state_t            w_state;
   write_state_t            w_next;
   logic                    aw_done;
   logic                    w_done;
   logic [AddressWidth-1:0] aw_addr_q;
   logic [31:0]             w_data_q;
   logic [3:0]              w_strb_q;
   logic [7:0]              w_count;
   logic                    w_legal;
   logic                    w_commit;
   logic [IndexWidth-1:0]   w_index;

   read_state_t             r_state;
   read_state_t             r_next;
   logic [AddressWidth-1:0] ar_addr_q;
   logic [7:0]              r_count;
   logic                    r_legal;
   logic                    r_load;

   assign w_legal  = is_legal(aw_addr_q);
   assign w_index  = to_index(aw_addr_q);
   assign w_commit = (w_state != W_RESP) && (w_next == W_RESP);
   assign r_legal  = is_legal(ar_addr_q);
   assign r_load   = (r_state != R_RESP) && (r_next == R_RESP);

   // Readies are held off for one full cycle after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_en <= 1'b0;
      else     ready_en <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE: if (aw_done && w_done) w_next = (ResponseLatency == 0) ? W_RESP : W_WAIT;
         W_WAIT: if (w_count == WaitLast) w_next = W_RESP;
         W_RESP: if (bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      awready = ready_en && (w_state == W_IDLE) && !aw_done;
      wready  = ready_en && (w_state == W_IDLE) && !w_done;
      bvalid  = (w_state == W_RESP);
      bresp   = ((w_state == W_RESP) && !w_legal) ? 2'b10 : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         w_count   <= '0;
      end else begin
         if (awvalid && awready) begin
            aw_done   <= 1'b1;
            aw_addr_q <= awaddr;
         end
         if (wvalid && wready) begin
            w_done   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if ((w_state == W_RESP) && bready) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         w_count <= (w_state == W_WAIT) ? w_count + 8'd1 : 8'd0;
      end
   end

   // Registers commit on the edge that enters W_RESP, so a write aborted by reset never lands.
   for (genvar i = 0; i < RegisterCount; i++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) regs[i] <= '0;
         else if (w_commit && w_legal && (w_index == IndexWidth'(i)))
            regs[i] <= merge_lanes(regs[i], w_data_q, w_strb_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE: if (arvalid && arready) r_next = R_WAIT;
         R_WAIT: if (r_count == ReadWait) r_next = R_RESP;
         R_RESP: if (rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      arready = ready_en && (r_state == R_IDLE);
      rvalid  = (r_state == R_RESP);
      rresp   = ((r_state == R_RESP) && !r_legal) ? 2'b10 : 2'b00;
   end

   // rdata is sampled with nonblocking semantics, so a same-edge write is not yet visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_addr_q <= '0;
         r_count   <= '0;
         rdata     <= '0;
      end else begin
         if (arvalid && arready) ar_addr_q <= araddr;
         r_count <= (r_state == R_WAIT) ? r_count + 8'd1 : 8'd0;
         if (r_load) rdata <= r_legal ? regs[to_index(ar_addr_q)] : 32'h0;
      end
   end

endmodule

// File: tb/tb_axi_lite_register_responder.sv
// Bench for axi_lite_register_responder: directed corner cases plus random traffic
// checked against an array model; a second instance with a 5-cycle delay covers waits and reset abort.
`timescale 1ns/1ps

module tb_axi_lite_register_responder;

   localparam int AddrW       = 20;
   localparam int RegCount    = 16;
   localparam int Base        = 0;
   localparam int FastLatency = 0;
   localparam int SlowLatency = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic             awvalid, awready, wvalid, wready, bvalid, bready;
   logic             arvalid, arready, rvalid, rready;
   logic [AddrW-1:0] awaddr, araddr;
   logic [31:0]      wdata, rdata;
   logic [3:0]       wstrb;
   logic [1:0]       bresp, rresp;

   logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic             s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AddrW-1:0] s_awaddr, s_araddr;
   logic [31:0]      s_wdata, s_rdata;
   logic [3:0]       s_wstrb;
   logic [1:0]       s_bresp, s_rresp;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] model_regs [RegCount];

   axi_lite_register_responder #(
      .AddressWidth(AddrW), .RegisterCount(RegCount), .BaseAddress(Base), .ResponseLatency(FastLatency)
   ) u_dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   axi_lite_register_responder #(
      .AddressWidth(AddrW), .RegisterCount(RegCount), .BaseAddress(Base), .ResponseLatency(SlowLatency)
   ) u_dut_slow (
      .clk(clk), .rst(rst),
      .awvalid(s_awvalid), .awready(s_awready), .awaddr(s_awaddr),
      .wvalid(s_wvalid), .wready(s_wready), .wdata(s_wdata), .wstrb(s_wstrb),
      .bvalid(s_bvalid), .bready(s_bready), .bresp(s_bresp),
      .arvalid(s_arvalid), .arready(s_arready), .araddr(s_araddr),
      .rvalid(s_rvalid), .rready(s_rready), .rdata(s_rdata), .rresp(s_rresp)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_legal(input logic [AddrW-1:0] addr);
      int unsigned a;
      a = addr;
      return (a >= Base) && (a % 4 == 0) && ((a - Base) / 4 < RegCount);
   endfunction

   function automatic int model_index(input logic [AddrW-1:0] addr);
      int unsigned a;
      a = addr;
      return int'((a - Base) / 4);
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] old_value, input logic [31:0] data,
                                               input logic [3:0] strb);
      logic [31:0] result;
      result = old_value;
      for (int b = 0; b < 4; b++) if (strb[b]) result[8*b +: 8] = data[8*b +: 8];
      return result;
   endfunction

   // order: 0 = AW and W together, 1 = AW first, 2 = W first
   task automatic write_txn(input logic [AddrW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int order, input int stall);
      bit aw_pend = 1'b1;
      bit w_pend = 1'b1;
      int guard = 0;
      int lat = 0;
      logic aw_hs, w_hs;
      logic [1:0] exp_resp;
      exp_resp = model_legal(addr) ? 2'b00 : 2'b10;
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = (order != 2);
      wvalid  = (order != 1);
      while ((aw_pend || w_pend) && guard < 50) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         guard++;
         if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_hs)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
         if (!aw_pend && w_pend && !wvalid) wvalid = 1'b1;
         if (!w_pend && aw_pend && !awvalid) awvalid = 1'b1;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      checkOutput("aw_w_accept", 32'({aw_pend, w_pend}), 32'h0);
      while (!bvalid && lat < 300) begin tick(); lat++; end
      checkOutput("b_latency", 32'(lat), 32'(1 + FastLatency));
      checkOutput("bresp", 32'(bresp), 32'(exp_resp));
      repeat (stall) begin
         tick();
         checkOutput("b_hold", 32'({bvalid, bresp}), 32'({1'b1, exp_resp}));
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checkOutput("b_drop", 32'(bvalid), 32'h0);
      if (model_legal(addr))
         model_regs[model_index(addr)] = model_merge(model_regs[model_index(addr)], data, strb);
   endtask

   task automatic read_txn(input logic [AddrW-1:0] addr, input int stall);
      int guard = 0;
      int lat = 0;
      logic [31:0] exp_data;
      logic [1:0] exp_resp;
      exp_data = model_legal(addr) ? model_regs[model_index(addr)] : 32'h0;
      exp_resp = model_legal(addr) ? 2'b00 : 2'b10;
      araddr  = addr;
      arvalid = 1'b1;
      while (!arready && guard < 50) begin tick(); guard++; end
      checkOutput("ar_accept", 32'(arready), 32'h1);
      tick();
      arvalid = 1'b0;
      while (!rvalid && lat < 300) begin tick(); lat++; end
      checkOutput("r_latency", 32'(lat), 32'(1 + FastLatency));
      checkOutput("rdata", rdata, exp_data);
      checkOutput("rresp", 32'(rresp), 32'(exp_resp));
      repeat (stall) begin
         tick();
         checkOutput("r_hold", rdata, exp_data);
         checkOutput("r_hold_valid", 32'({rvalid, rresp}), 32'({1'b1, exp_resp}));
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checkOutput("r_drop", 32'(rvalid), 32'h0);
   endtask

   task automatic s_read(input logic [AddrW-1:0] addr, input logic [31:0] exp_data);
      int guard = 0;
      int lat = 0;
      s_araddr  = addr;
      s_arvalid = 1'b1;
      while (!s_arready && guard < 50) begin tick(); guard++; end
      tick();
      s_arvalid = 1'b0;
      while (!s_rvalid && lat < 300) begin tick(); lat++; end
      checkOutput("slow_r_latency", 32'(lat), 32'(1 + SlowLatency));
      checkOutput("slow_rdata", s_rdata, exp_data);
      checkOutput("slow_rresp", 32'(s_rresp), 32'h0);
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
   endtask

   // One random transaction on the fast instance; address mix favours legal registers.
   task automatic applyStimulus();
      logic [AddrW-1:0] addr;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      addr = AddrW'(Base + 4 * $urandom_range(0, RegCount - 1));
      else if (sel == 7) addr = AddrW'(Base + 4 * $urandom_range(0, RegCount - 1) + $urandom_range(1, 3));
      else if (sel == 8) addr = AddrW'(Base + 4 * RegCount + 4 * $urandom_range(0, 15));
      else               addr = AddrW'($urandom);
      if ($urandom_range(0, 1) == 0)
         write_txn(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3));
      else
         read_txn(addr, $urandom_range(0, 3));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      int lat;
      rst = 1'b1;
      {awvalid, wvalid, bready, arvalid, rready} = '0;
      {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready} = '0;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
      for (int i = 0; i < RegCount; i++) model_regs[i] = 32'h0;

      repeat (3) tick();
      checkOutput("reset_outputs", 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);
      rst = 1'b0;
      checkOutput("readies_first_cycle", 32'({awready, wready, arready}), 32'h0);
      tick();
      checkOutput("readies_second_cycle", 32'({awready, wready, arready}), 32'h7);

      // Concurrent write and read of register 0 committing on the same edge.
      awaddr = 'h0; wdata = 32'h5; wstrb = 4'hF; araddr = 'h0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      checkOutput("concurrent_readies", 32'({awready, wready, arready}), 32'h7);
      tick();
      {awvalid, wvalid, arvalid} = '0;
      tick();
      checkOutput("concurrent_valids", 32'({bvalid, rvalid}), 32'h3);
      checkOutput("concurrent_rdata_old", rdata, model_regs[0]);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      checkOutput("concurrent_drop", 32'({bvalid, rvalid}), 32'h0);
      model_regs[0] = 32'h5;
      read_txn('h0, 0);

      write_txn('h8, 32'hDEADBEEF, 4'hF, 0, 0);
      read_txn('h8, 0);
      write_txn('h4, 32'h11223344, 4'hF, 1, 1);
      write_txn('h4, 32'hAABBCCDD, 4'b0101, 2, 0);
      read_txn('h4, 1);
      write_txn('h40, 32'hCAFEF00D, 4'hF, 0, 2);
      read_txn('h6, 1);
      read_txn('h0, 0);
      read_txn('h8, 0);

      for (int n = 0; n < 60; n++) applyStimulus();
      for (int i = 0; i < RegCount; i++) read_txn(AddrW'(Base + 4 * i), 0);

      // Slow instance: W leads AW by three cycles, then a stalled response.
      s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
      guard = 0;
      while (!s_wready && guard < 50) begin tick(); guard++; end
      tick();
      s_wvalid = 1'b0;
      tick();
      tick();
      s_awaddr = 'hC; s_awvalid = 1'b1;
      checkOutput("slow_awready", 32'(s_awready), 32'h1);
      tick();
      s_awvalid = 1'b0;
      lat = 0;
      while (!s_bvalid && lat < 300) begin tick(); lat++; end
      checkOutput("slow_b_latency", 32'(lat), 32'(1 + SlowLatency));
      checkOutput("slow_b_start", 32'({s_bvalid, s_bresp}), 32'h4);
      repeat (4) begin
         tick();
         checkOutput("slow_b_hold", 32'({s_bvalid, s_bresp}), 32'h4);
      end
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      checkOutput("slow_b_drop", 32'(s_bvalid), 32'h0);
      s_read('hC, 32'h12345678);

      // Reset lands while a write of register 0 sits in its wait phase.
      s_awaddr = 'h0; s_wdata = 32'h1; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      checkOutput("slow_abort_readies", 32'({s_awready, s_wready}), 32'h3);
      tick();
      {s_awvalid, s_wvalid} = '0;
      tick();
      tick();
      rst = 1'b1;
      #2;
      checkOutput("abort_reset_outputs",
                  32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp}), 32'h0);
      checkOutput("abort_reset_rdata", s_rdata, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("abort_readies_first", 32'({s_awready, s_wready, s_arready}), 32'h0);
      tick();
      checkOutput("abort_readies_second", 32'({s_awready, s_wready, s_arready}), 32'h7);
      s_read('h0, 32'h0);
      s_read('hC, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
